// File: rtl/instr_sequencer.sv
// Instruction sequencer: loadable program memory plus program counter that
// feeds simple_cpu one instruction at a time, each held for a fixed number of
// cycles, and stops on a HALT opcode or at the last memory word.
module instr_sequencer #(
    parameter int unsigned               INSTR_WIDTH      = 20,
    parameter int unsigned               PC_BITS          = 5,
    parameter int unsigned               CYCLES_PER_INSTR = 3,
    parameter logic [3:0]                HALT_OPCODE      = 4'hF,
    parameter logic [INSTR_WIDTH-1:0]    NOP_INSTR        = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   start,
    input  logic                   abort,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned Depth = 2 ** PC_BITS;
    // Keep the hold counter at least one bit wide when CYCLES_PER_INSTR is 1.
    localparam int unsigned CntW  = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(CYCLES_PER_INSTR - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StHalted
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] fetch;
    logic                   load_ok;

    logic [INSTR_WIDTH-1:0] mem [Depth];

    assign load_ok = load_en && ((state_q == StIdle) || (state_q == StHalted));

    // Program memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; abort overrides every state and the hold counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fetch   = mem[pc_q];

        if (abort) begin
            state_d = StIdle;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StHalted: begin
                    // A simultaneous load wins over start.
                    if (start && !load_en) begin
                        pc_d    = '0;
                        state_d = StIssue;
                    end
                end
                StIssue: begin
                    // HALT words are consumed here and never reach the CPU.
                    if (fetch[INSTR_WIDTH-1 -: 4] == HALT_OPCODE) begin
                        state_d = StHalted;
                    end else begin
                        instr_d = fetch;
                        valid_d = 1'b1;
                        cnt_d   = CntLoad;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                        if (&pc_q) begin
                            state_d = StHalted;
                        end else begin
                            pc_d    = pc_q + PC_BITS'(1);
                            state_d = StIssue;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == StIssue) || (state_q == StWait);
    assign done        = (state_q == StHalted);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer with immediate-assertion checks.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [19:0] load_data;
    logic        start;
    logic        abort;
    logic [19:0] instruction;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .abort       (abort),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; drive and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [19:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Pulse start; returns with the DUT in its ISSUE cycle.
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic load_prog2();
        load(5'd0, 20'h12345);
        load(5'd1, 20'h20A0B);
        load(5'd2, 20'hF0000);
    endtask

    initial begin
        rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; abort = 1'b0;
        #1;

        // 1: reset
        tick(); tick();
        rst = 1'b1;
        chk("rst_instr", 32'(instruction), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc",    32'(pc),          32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);

        // 2: two instructions then HALT
        load_prog2();
        go();
        chk("s2_issue_busy",  32'(busy),        32'd1);
        chk("s2_issue_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_i0_instr", 32'(instruction), 32'h12345);
            chk("s2_i0_valid", 32'(instr_valid), 32'd1);
        end
        tick();
        chk("s2_gap_valid", 32'(instr_valid), 32'd0);
        chk("s2_gap_instr", 32'(instruction), 32'h0);
        chk("s2_gap_pc",    32'(pc),          32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_i1_instr", 32'(instruction), 32'h20A0B);
            chk("s2_i1_valid", 32'(instr_valid), 32'd1);
        end
        tick();
        chk("s2_drop_valid", 32'(instr_valid), 32'd0);
        chk("s2_drop_done",  32'(done),        32'd0);
        tick();
        chk("s2_done",       32'(done),        32'd1);
        chk("s2_halt_valid", 32'(instr_valid), 32'd0);
        chk("s2_halt_instr", 32'(instruction), 32'h0);
        chk("s2_halt_busy",  32'(busy),        32'd0);
        chk("s2_halt_pc",    32'(pc),          32'd2);

        // 3: full memory, no HALT, no wrap
        for (int i = 0; i < 32; i++) begin
            load(5'(i), {4'h1, 16'(i)});
        end
        go();
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("s3_instr", 32'(instruction), 32'({4'h1, 16'(i)}));
            chk("s3_pc",    32'(pc),          32'(i));
            tick(); tick(); tick();
        end
        chk("s3_done",  32'(done),        32'd1);
        chk("s3_pc_end", 32'(pc),         32'd31);
        chk("s3_valid", 32'(instr_valid), 32'd0);

        // 4: abort on 2nd valid cycle of instruction 1
        load_prog2();
        go();
        tick(); tick(); tick(); tick();
        tick();
        chk("s4_i1_first", 32'(instruction), 32'h20A0B);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_ab_valid", 32'(instr_valid), 32'd0);
        chk("s4_ab_instr", 32'(instruction), 32'h0);
        chk("s4_ab_busy",  32'(busy),        32'd0);
        chk("s4_ab_done",  32'(done),        32'd0);
        chk("s4_ab_pc",    32'(pc),          32'd1);
        go();
        chk("s4_re_pc", 32'(pc), 32'd0);
        tick();
        chk("s4_re_instr", 32'(instruction), 32'h12345);
        wait_done("s4_wait_done");

        // 5: load while busy is ignored; load in HALTED takes effect
        go();
        tick();
        load(5'd1, 20'h3FFFF);
        tick(); tick(); tick();
        chk("s5_busy_load_ignored", 32'(instruction), 32'h20A0B);
        wait_done("s5_wait_done1");
        load(5'd1, 20'h3FFFF);
        go();
        tick(); tick(); tick(); tick(); tick();
        chk("s5_halted_load", 32'(instruction), 32'h3FFFF);
        wait_done("s5_wait_done2");

        // 6: load+start together in IDLE, then HALT at word 0
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s6_idle_done", 32'(done), 32'd0);
        load_en = 1'b1; load_addr = 5'd0; load_data = 20'hF0000; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        chk("s6_ls_busy", 32'(busy), 32'd0);
        tick();
        chk("s6_ls_busy2", 32'(busy), 32'd0);
        go();
        chk("s6_issue_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("s6_done",  32'(done),        32'd1);
        chk("s6_valid", 32'(instr_valid), 32'd0);
        chk("s6_pc",    32'(pc),          32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
